// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3, one adjust+shift per
//   clock). Accepts an unsigned or two's complement input, converts its
//   magnitude and saturates the result to all nines when it does not fit in
//   DIGITS decimal digits. Results appear DATA_W+1 cycles after the start edge.
//
// Ports
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   start      in   conversion request, sampled only while idle
//   sign_en    in   1 = data_in is two's complement (sampled with start)
//   data_in    in   [DATA_W-1:0] binary value (sampled with start)
//   busy       out  high while a conversion is in progress
//   done       out  one-cycle pulse when bcd_out/neg/overflow update
//   bcd_out    out  [4*DIGITS-1:0] result, digit i in [4i+3:4i]
//   neg        out  1 = input was negative (never set for a zero magnitude)
//   overflow   out  magnitude >= 10^DIGITS, bcd_out saturated to all nines
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int DATA_W = 20,
  parameter int DIGITS = 6
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic                  sign_en,
  input  logic [DATA_W-1:0]     data_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Magnitude of the input. The most-negative value wraps back onto itself,
  // which read as unsigned is exactly 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] d,
                                                  input logic              sgn);
    logic signed [DATA_W-1:0] s;
    s = signed'(d);
    if (sgn && (s < 0))
      return $unsigned(-s);
    else
      return d;
  endfunction

  // Add 3 to every digit above 4; digits are independent (no carry).
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd4)
        r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] bcd,
                                                input logic             ovf);
    return ovf ? {DIGITS{4'h9}} : bcd;
  endfunction

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [BCD_W-1:0]    bcd_sr;
  logic [DATA_W-1:0]   mag_sr;
  logic                sign_r;
  logic                mag_zero;
  logic                ovf_flag;

  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_nxt;
  logic [DATA_W-1:0]   mag_nxt;
  logic                carry_out;

  assign bcd_adj = add3_digits(bcd_sr);
  // carry_out is the bit leaving the top digit; any 1 here means the value
  // needs more than DIGITS digits.
  assign {carry_out, bcd_nxt, mag_nxt} = {bcd_adj, mag_sr, 1'b0};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bcd_sr   <= '0;
      mag_sr   <= '0;
      sign_r   <= 1'b0;
      mag_zero <= 1'b0;
      ovf_flag <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      neg      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_sr   <= magnitude(data_in, sign_en);
            sign_r   <= sign_en & data_in[DATA_W-1];
            mag_zero <= (data_in == '0);
            bcd_sr   <= '0;
            ovf_flag <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_sr <= bcd_nxt;
          mag_sr <= mag_nxt;
          if (carry_out)
            ovf_flag <= 1'b1;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP)
            state <= FINISH;
        end
        FINISH: begin
          bcd_out  <= saturate(bcd_sr, ovf_flag);
          neg      <= sign_r & ~mag_zero;
          overflow <= ovf_flag;
          done     <= 1'b1;
          busy     <= 1'b0;
          cnt      <= '0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;

  logic        st20, s20;
  logic [19:0] d20;
  logic        busy20, done20, neg20, ovf20;
  logic [23:0] bcd20;

  logic        st8, s8;
  logic [7:0]  d8;
  logic        busy8, done8, neg8, ovf8;
  logic [7:0]  bcd8;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;
  int lat, bcnt;

  bin2bcd_seq #(.DATA_W(20), .DIGITS(6)) u20 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(st20), .sign_en(s20),
    .data_in(d20), .busy(busy20), .done(done20), .bcd_out(bcd20),
    .neg(neg20), .overflow(ovf20));

  bin2bcd_seq #(.DATA_W(8), .DIGITS(2)) u8 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(st8), .sign_en(s8),
    .data_in(d8), .busy(busy8), .done(done8), .bcd_out(bcd8),
    .neg(neg8), .overflow(ovf8));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] din;
    bit          sgn;
    logic [23:0] bcd;
    bit          neg;
    bit          ovf;
  } vec_t;

  vec_t tbl20[8];
  vec_t tbl8[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the magnitude, decimal digits by %10.
  function automatic void model(input longint unsigned din, input bit sgn,
                                input int w, input int digits,
                                output logic [23:0] bcd, output bit ng, output bit ov);
    longint unsigned mag, lim;
    bit msb;
    msb = ((din >> (w - 1)) & 1) != 0;
    mag = (sgn && msb) ? ((64'd1 << w) - din) : din;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    ov  = (mag >= lim);
    ng  = sgn && msb && (mag != 0);
    bcd = '0;
    for (int i = 0; i < digits; i++) begin
      if (ov) bcd[4*i +: 4] = 4'd9;
      else begin
        bcd[4*i +: 4] = 4'(mag % 10);
        mag = mag / 10;
      end
    end
  endfunction

  // One conversion on the 20-bit instance; lat = cycles from start edge to done,
  // bcnt = samples with busy high from the start edge onward.
  task automatic conv20(input logic [19:0] din, input bit sgn);
    int c0;
    @(negedge clk); d20 = din; s20 = sgn; st20 = 1'b1;
    @(posedge clk); #1; c0 = cyc; bcnt = busy20 ? 1 : 0; lat = -1;
    @(negedge clk); st20 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done20) begin lat = cyc - c0; break; end
      if (busy20) bcnt++;
    end
  endtask

  task automatic conv8(input logic [7:0] din, input bit sgn);
    int c0;
    @(negedge clk); d8 = din; s8 = sgn; st8 = 1'b1;
    @(posedge clk); #1; c0 = cyc; lat = -1;
    @(negedge clk); st8 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done8) begin lat = cyc - c0; break; end
    end
  endtask

  initial begin
    logic [23:0] eb;
    bit en, eo;
    logic [19:0] a, b;
    int t[3];
    int seen, dcnt;

    tbl20[0] = '{20'd999999,  1'b0, 24'h999999, 1'b0, 1'b0};
    tbl20[1] = '{20'd0,       1'b0, 24'h000000, 1'b0, 1'b0};
    tbl20[2] = '{20'd1048575, 1'b0, 24'h999999, 1'b0, 1'b1};
    tbl20[3] = '{20'hFFFFF,   1'b1, 24'h000001, 1'b1, 1'b0};
    tbl20[4] = '{20'h80000,   1'b1, 24'h524288, 1'b1, 1'b0};
    tbl20[5] = '{20'h7FFFF,   1'b1, 24'h524287, 1'b0, 1'b0};
    tbl20[6] = '{20'd12345,   1'b0, 24'h012345, 1'b0, 1'b0};
    tbl20[7] = '{20'd1000000, 1'b0, 24'h999999, 1'b0, 1'b1};
    tbl8[0]  = '{20'd99,  1'b0, 24'h99, 1'b0, 1'b0};
    tbl8[1]  = '{20'd100, 1'b0, 24'h99, 1'b0, 1'b1};
    tbl8[2]  = '{20'h80,  1'b1, 24'h99, 1'b1, 1'b1};
    tbl8[3]  = '{20'hFF,  1'b1, 24'h01, 1'b1, 1'b0};

    rst_n = 1'b0; st20 = 0; s20 = 0; d20 = '0; st8 = 0; s8 = 0; d8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy20}, 0);
    chk("rst_done", {31'd0, done20}, 0);
    chk("rst_bcd",  {8'd0, bcd20}, 0);
    chk("rst_neg",  {31'd0, neg20}, 0);
    chk("rst_ovf",  {31'd0, ovf20}, 0);
    chk("rst_bcd8", {24'd0, bcd8}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed table, 20-bit / 6 digits
    for (int i = 0; i < 8; i++) begin
      conv20(tbl20[i].din, tbl20[i].sgn);
      chk($sformatf("tbl%0d_lat", i),  lat, 21);
      chk($sformatf("tbl%0d_busy", i), bcnt, 21);
      chk($sformatf("tbl%0d_bcd", i),  {8'd0, bcd20}, {8'd0, tbl20[i].bcd});
      chk($sformatf("tbl%0d_neg", i),  {31'd0, neg20}, {31'd0, tbl20[i].neg});
      chk($sformatf("tbl%0d_ovf", i),  {31'd0, ovf20}, {31'd0, tbl20[i].ovf});
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_done1", i), {31'd0, done20}, 0);
      chk($sformatf("tbl%0d_hold", i), {8'd0, bcd20}, {8'd0, tbl20[i].bcd});
    end

    // Directed table, 8-bit / 2 digits
    for (int i = 0; i < 4; i++) begin
      conv8(tbl8[i].din[7:0], tbl8[i].sgn);
      chk($sformatf("t8_%0d_lat", i), lat, 9);
      chk($sformatf("t8_%0d_bcd", i), {24'd0, bcd8}, {24'd0, tbl8[i].bcd[7:0]});
      chk($sformatf("t8_%0d_neg", i), {31'd0, neg8}, {31'd0, tbl8[i].neg});
      chk($sformatf("t8_%0d_ovf", i), {31'd0, ovf8}, {31'd0, tbl8[i].ovf});
    end

    // Random against the reference model
    for (int i = 0; i < 30; i++) begin
      a  = 20'($urandom);
      en = 1'($urandom);
      if (i % 5 == 0) a = 20'($urandom_range(999990, 1000010));
      conv20(a, en);
      model(64'(a), en, 20, 6, eb, en, eo);
      chk($sformatf("r20_%0d_lat", i), lat, 21);
      chk($sformatf("r20_%0d_bcd", i), {8'd0, bcd20}, {8'd0, eb});
      chk($sformatf("r20_%0d_neg", i), {31'd0, neg20}, {31'd0, en});
      chk($sformatf("r20_%0d_ovf", i), {31'd0, ovf20}, {31'd0, eo});
    end
    for (int i = 0; i < 20; i++) begin
      logic [7:0] v;
      bit sg;
      v  = 8'($urandom_range(0, 255));
      sg = 1'($urandom);
      conv8(v, sg);
      model(64'(v), sg, 8, 2, eb, en, eo);
      chk($sformatf("r8_%0d_bcd", i), {24'd0, bcd8}, {24'd0, eb[7:0]});
      chk($sformatf("r8_%0d_neg", i), {31'd0, neg8}, {31'd0, en});
      chk($sformatf("r8_%0d_ovf", i), {31'd0, ovf8}, {31'd0, eo});
    end

    // Second start 5 cycles into a conversion is ignored
    a = 20'd314159; b = 20'd271828;
    begin
      int c0;
      @(negedge clk); d20 = a; s20 = 1'b0; st20 = 1'b1;
      @(posedge clk); #1; c0 = cyc;
      @(negedge clk); st20 = 1'b0; d20 = b; s20 = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk); st20 = 1'b1;
      @(negedge clk); st20 = 1'b0;
      lat = -1;
      for (int k = 0; k < 60; k++) begin
        @(posedge clk); #1;
        if (done20) begin lat = cyc - c0; break; end
      end
      chk("ign_lat", lat, 21);
      chk("ign_bcd", {8'd0, bcd20}, 32'h00314159);
      chk("ign_neg", {31'd0, neg20}, 0);
      repeat (3) @(posedge clk); #1;
      chk("ign_idle", {31'd0, busy20}, 0);
    end

    // start held high: back-to-back conversions
    @(negedge clk); d20 = 20'd65536; s20 = 1'b0; st20 = 1'b1;
    seen = 0; t[0] = 0; t[1] = 0; t[2] = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (done20) begin
        t[seen] = cyc;
        chk($sformatf("b2b_%0d_bcd", seen), {8'd0, bcd20}, 32'h00065536);
        seen++;
        if (seen == 3) break;
      end
    end
    @(negedge clk); st20 = 1'b0;
    chk("b2b_count", seen, 3);
    chk("b2b_gap1", t[1] - t[0], 22);
    chk("b2b_gap2", t[2] - t[1], 22);
    repeat (3) @(posedge clk); #1;
    chk("b2b_stop", {31'd0, busy20}, 0);

    // Asynchronous reset mid-conversion
    conv20(20'hFFFFF, 1'b1);
    chk("pre_rst_neg", {31'd0, neg20}, 1);
    @(negedge clk); d20 = 20'd777777; s20 = 1'b0; st20 = 1'b1;
    @(posedge clk); @(negedge clk); st20 = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    chk("arst_busy", {31'd0, busy20}, 0);
    chk("arst_bcd",  {8'd0, bcd20}, 0);
    chk("arst_neg",  {31'd0, neg20}, 0);
    chk("arst_ovf",  {31'd0, ovf20}, 0);
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done20 || busy20) dcnt++;
    end
    chk("post_rst_quiet", dcnt, 0);
    conv20(20'd777777, 1'b0);
    chk("post_rst_lat", lat, 21);
    chk("post_rst_bcd", {8'd0, bcd20}, 32'h00777777);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using the shift-and-add-3 algorithm, with one adjust and shift per clock. It is the generalised successor of the fixed 20-bit/6-digit free-running converter. It adds configurable width and digit count, a start/busy/done handshake, signed (two's complement) input mode and overflow saturation. It sits between the datapath and the seven-segment display driver.

Parameters:
DATA_W, 20, width of binary input (>=4).
DIGITS, 6, number of BCD output digits (>=1).

Ports:
sys_clk  input  1  system clock, rising edge.
sys_rst_n  input  1  asynchronous active-low reset.
start  input  1  conversion request; sampled only while idle.
sign_en  input  1  1 = treat data_in as two's complement; sampled with start.
data_in  input  DATA_W  binary value; sampled with start.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse when results update.
bcd_out  output  4*DIGITS  result; digit 0 (units) in [3:0], digit i in [4i+3:4i].
neg  output  1  result sign; 1 = input was negative.
overflow  output  1  magnitude >= 10^DIGITS; bcd_out saturated.

Behaviour:
- Reset (async, any time including mid-conversion): state IDLE, counter 0, shift register 0, busy=0, done=0, bcd_out=0, neg=0, overflow=0.
- FSM states:
  - IDLE -> SHIFT on start=1 (edge E0).
  - SHIFT -> FINISH after DATA_W shift steps.
  - FINISH -> IDLE unconditionally.
- Edge E0 (start accepted):
  - Capture magnitude: if sign_en=1 and data_in[DATA_W-1]=1, magnitude = (~data_in + 1) as DATA_W-bit unsigned, so the most-negative input gives 2^(DATA_W-1). Otherwise magnitude = data_in.
  - Capture sign bit. Clear BCD accumulator and the sticky overflow flag. Set busy=1.
- Edges E1..E_DATA_W (SHIFT), one step per edge:
  - Every BCD digit > 4 gets +3 (4-bit, no carry between digits).
  - Then {BCD, magnitude} shifts left by 1.
  - If the bit shifted out of the top digit is 1, the sticky overflow flag is set.
  - Shift counter width is clog2(DATA_W+1); SHIFT is left when the counter reaches DATA_W-1 with the step applied.
- Edge E_(DATA_W+1) (FINISH):
  - bcd_out <= accumulator, or all digits 4'h9 if the overflow flag is set.
  - neg <= captured sign, except neg=0 when the magnitude is 0.
  - overflow <= flag; done=1 for exactly one cycle; busy=0; state -> IDLE.
- Latency: results and done are visible DATA_W+1 cycles after the start edge. Throughput is one conversion per DATA_W+2 cycles.
- start while busy=1 is ignored, with no queuing; data_in/sign_en changes while busy have no effect.
- start=1 in the cycle done=1 is accepted, because the state is already IDLE.
- bcd_out/neg/overflow hold their last values between done pulses and are never partially updated.
- sign_en=0: data_in[DATA_W-1] is a magnitude bit and neg is always 0.

Test Plan:
- DATA_W=20, DIGITS=6, sign_en=0, data_in=999999, pulse start -> done pulses exactly 21 cycles after the start edge; bcd_out=24'h999999, overflow=0, neg=0; busy high 21 cycles.
- data_in=0 -> bcd_out=24'h000000, neg=0. Then data_in=20'd1048575 -> overflow=1, bcd_out=24'h999999.
- sign_en=1: data_in=20'hFFFFF gives neg=1, bcd_out=24'h000001. data_in=20'h80000 gives neg=1, bcd_out=24'h524288. data_in=20'h7FFFF gives neg=0, bcd_out=24'h524287.
- Second start pulsed 5 cycles into a conversion with a different data_in -> ignored; result matches the first data_in. start held high continuously -> back-to-back conversions, done every 22 cycles.
- Assert sys_rst_n=0 mid-conversion (cycle 10) -> all outputs 0 immediately. After release, no done until a new start, then a correct result.
- DATA_W=8, DIGITS=2: data_in=99 gives bcd_out=8'h99, overflow=0. data_in=100 gives overflow=1, bcd_out=8'h99. done arrives 9 cycles after start.
